mux_n_1_arb: RTL

//  Parametrised N:1 datapath selector with registered output and valid/ready flow control.

---
 rtl/mux_pkg.sv | 5 +
 rtl/mux_n_1_arb_if.sv | 23 ++
 rtl/rr_arbiter.sv | 23 ++
 rtl/mux_n_1_arb.sv | 50 +++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: select-mode constants shared by the N:1 selector and its bench
package mux_pkg;
  localparam int MODE_EXT_SEL     = 0;
  localparam int MODE_ROUND_ROBIN = 1;
endpackage

// File: rtl/mux_n_1_arb_if.sv
// mux_n_1_arb_if: channel-side and output-side valid/ready bundle of the N:1 selector
interface mux_n_1_arb_if #(
  parameter int WIDTH = 8,
  parameter int CH = 4,
  localparam int SELW = $clog2(CH)
);
  logic [CH*WIDTH-1:0] in_data;
  logic [CH-1:0] in_valid;
  logic [CH-1:0] in_ready;
  logic [SELW-1:0] sel;
  logic [WIDTH-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic [SELW-1:0] out_ch;
  modport slave (
    input in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
  modport master (
    output in_data, in_valid, sel, out_ready,
    input in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant to the first requester at or after ptr, wrapping
module rr_arbiter #(
  parameter int CH = 4,
  localparam int SELW = $clog2(CH)
) (
  input  logic [CH-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic [CH-1:0] grant
);
  logic found;
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < CH; i++) begin
      int j;
      j = (int'(ptr) + i) % CH;
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_n_1_arb.sv
// mux_n_1_arb: N:1 word selector (external select or round-robin) with registered valid/ready output
module mux_n_1_arb import mux_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CH = 4,
  parameter int MODE = MODE_EXT_SEL,
  localparam int SELW = $clog2(CH)
) (
  input logic clk,
  input logic rst,
  mux_n_1_arb_if.slave bus
);
  logic [CH-1:0] g;
  logic [SELW-1:0] gidx;
  logic can_load, accept;
  logic [WIDTH-1:0] data_q;
  logic valid_q;
  logic [SELW-1:0] ch_q;
  assign can_load = !valid_q | bus.out_ready;
  assign accept = |(g & bus.in_valid) & can_load;
  assign bus.in_ready = g & {CH{can_load}};
  assign bus.out_data = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_ch = ch_q;
  generate
    if (MODE == MODE_ROUND_ROBIN) begin : g_rr
      logic [SELW-1:0] rr_ptr;
      rr_arbiter #(.CH(CH)) u_arb (.req(bus.in_valid), .ptr(rr_ptr), .grant(g));
      always_ff @(posedge clk or posedge rst)
        if (rst) rr_ptr <= '0;
        else if (accept) rr_ptr <= (gidx == SELW'(CH - 1)) ? '0 : SELW'(gidx + 1'b1);
    end else begin : g_ext
      // sel values past the last channel grant nothing
      assign g = ({1'b0, bus.sel} < (SELW + 1)'(CH)) ? CH'(1) << bus.sel : '0;
    end
  endgenerate
  always_comb begin
    gidx = '0;
    for (int i = 0; i < CH; i++) gidx = g[i] ? SELW'(i) : gidx;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data_q <= '0;
      valid_q <= 1'b0;
      ch_q <= '0;
    end else if (accept) begin
      data_q <= bus.in_data[int'(gidx)*WIDTH +: WIDTH];
      valid_q <= 1'b1;
      ch_q <= gidx;
    end else if (bus.out_ready) valid_q <= 1'b0;
endmodule
